// File: rtl/video_blitter_if.sv
// Register-port and video-memory-port bundle for video_blitter.
// The master side drives configuration and memory read data; the blitter is the slave.
interface video_blitter_if;
  logic        cfg_en;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_write;
  logic [31:0] cfg_read;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write;
  logic [31:0] mem_read;
  logic        irq;

  modport master (
    output cfg_en, cfg_we, cfg_addr, cfg_write, mem_read,
    input  cfg_read, mem_en, mem_we, mem_addr, mem_write, irq
  );

  modport slave (
    input  cfg_en, cfg_we, cfg_addr, cfg_write, mem_read,
    output cfg_read, mem_en, mem_we, mem_addr, mem_write, irq
  );
endinterface

// File: rtl/video_blitter.sv
// Rectangle fill/copy engine that masters video_unit's memory port on mem_clk.
// Software programs geometry through the register port, then writes CTRL.start.
module video_blitter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DIM_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  video_blitter_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_COPY_RD = 2'd2;
  localparam logic [1:0] S_COPY_WR = 2'd3;

  localparam logic [3:0] REG_DST        = 4'd0;
  localparam logic [3:0] REG_SRC        = 4'd1;
  localparam logic [3:0] REG_WIDTH      = 4'd2;
  localparam logic [3:0] REG_HEIGHT     = 4'd3;
  localparam logic [3:0] REG_DST_STRIDE = 4'd4;
  localparam logic [3:0] REG_SRC_STRIDE = 4'd5;
  localparam logic [3:0] REG_FILL       = 4'd6;
  localparam logic [3:0] REG_CTRL       = 4'd7;
  localparam logic [3:0] REG_STATUS     = 4'd8;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_dst, r_src, r_dst_stride, r_src_stride;
  logic [DIM_WIDTH-1:0]  r_width, r_height;
  logic [31:0]           r_fill;
  logic                  r_mode, r_irq_en, r_done, r_aborted;
  logic [ADDR_WIDTH-1:0] r_dst_row, r_src_row, r_dst_ptr, r_src_ptr;
  logic [DIM_WIDTH-1:0]  r_col, r_row;
  logic [31:0]           r_cfg_read;

  logic                  w_busy, w_cfg_wr, w_start, w_abort, w_zero_dim;
  logic                  w_step, w_last_col, w_last_row, w_set_done, w_clr_done, w_clr_aborted;
  logic [ADDR_WIDTH-1:0] w_dst_row_next, w_src_row_next;
  logic [31:0]           w_rd_data;

  assign w_busy         = (r_state != S_IDLE);
  assign w_cfg_wr       = bus.cfg_en & bus.cfg_we;
  assign w_start        = w_cfg_wr && (bus.cfg_addr == REG_CTRL) && bus.cfg_write[0];
  assign w_abort        = w_cfg_wr && (bus.cfg_addr == REG_CTRL) && bus.cfg_write[3];
  assign w_zero_dim     = (r_width == '0) || (r_height == '0);
  assign w_step         = (r_state == S_FILL) || (r_state == S_COPY_WR);
  assign w_last_col     = (r_col == r_width - DIM_WIDTH'(1));
  assign w_last_row     = (r_row == r_height - DIM_WIDTH'(1));
  assign w_dst_row_next = r_dst_row + r_dst_stride;
  assign w_src_row_next = r_src_row + r_src_stride;

  // An abort landing on the final word's edge wins: the rectangle counts as aborted, not done.
  assign w_set_done    = w_busy ? (w_step && w_last_col && w_last_row && !w_abort)
                                : (w_start && w_zero_dim);
  assign w_clr_done    = w_cfg_wr && (bus.cfg_addr == REG_STATUS) && bus.cfg_write[1];
  assign w_clr_aborted = w_cfg_wr && (bus.cfg_addr == REG_STATUS) && bus.cfg_write[2];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst        <= '0;
      r_src        <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_dst_stride <= '0;
      r_src_stride <= '0;
      r_fill       <= '0;
      r_mode       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (w_cfg_wr && !w_busy) begin
        case (bus.cfg_addr)
          REG_DST:        r_dst        <= bus.cfg_write[ADDR_WIDTH-1:0];
          REG_SRC:        r_src        <= bus.cfg_write[ADDR_WIDTH-1:0];
          REG_WIDTH:      r_width      <= bus.cfg_write[DIM_WIDTH-1:0];
          REG_HEIGHT:     r_height     <= bus.cfg_write[DIM_WIDTH-1:0];
          REG_DST_STRIDE: r_dst_stride <= bus.cfg_write[ADDR_WIDTH-1:0];
          REG_SRC_STRIDE: r_src_stride <= bus.cfg_write[ADDR_WIDTH-1:0];
          REG_FILL:       r_fill       <= bus.cfg_write;
          REG_CTRL: begin
            r_mode   <= bus.cfg_write[1];
            r_irq_en <= bus.cfg_write[2];
          end
          default: ;
        endcase
      end
      r_done    <= w_set_done | (r_done & ~w_clr_done);
      r_aborted <= (w_busy & w_abort) | (r_aborted & ~w_clr_aborted);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dst_row <= '0;
      r_src_row <= '0;
      r_dst_ptr <= '0;
      r_src_ptr <= '0;
      r_col     <= '0;
      r_row     <= '0;
    end else if (w_busy && w_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start && !w_zero_dim) begin
            r_dst_row <= r_dst;
            r_dst_ptr <= r_dst;
            r_src_row <= r_src;
            r_src_ptr <= r_src;
            r_col     <= '0;
            r_row     <= '0;
            // Mode comes from the same CTRL write that carries start.
            r_state   <= bus.cfg_write[1] ? S_COPY_RD : S_FILL;
          end
        end
        S_COPY_RD: r_state <= S_COPY_WR;
        default: begin
          if (r_state == S_COPY_WR) r_state <= S_COPY_RD;
          if (!w_last_col) begin
            r_col     <= r_col + DIM_WIDTH'(1);
            r_dst_ptr <= r_dst_ptr + ADDR_WIDTH'(1);
            r_src_ptr <= r_src_ptr + ADDR_WIDTH'(1);
          end else if (!w_last_row) begin
            r_col     <= '0;
            r_row     <= r_row + DIM_WIDTH'(1);
            r_dst_row <= w_dst_row_next;
            r_src_row <= w_src_row_next;
            r_dst_ptr <= w_dst_row_next;
            r_src_ptr <= w_src_row_next;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_rd_data = '0;
    case (bus.cfg_addr)
      REG_DST:        w_rd_data = 32'(r_dst);
      REG_SRC:        w_rd_data = 32'(r_src);
      REG_WIDTH:      w_rd_data = 32'(r_width);
      REG_HEIGHT:     w_rd_data = 32'(r_height);
      REG_DST_STRIDE: w_rd_data = 32'(r_dst_stride);
      REG_SRC_STRIDE: w_rd_data = 32'(r_src_stride);
      REG_FILL:       w_rd_data = r_fill;
      REG_CTRL:       w_rd_data = {29'd0, r_irq_en, r_mode, 1'b0};
      REG_STATUS:     w_rd_data = {29'd0, r_aborted, r_done, w_busy};
      default:        w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_read <= '0;
    end else if (bus.cfg_en && !bus.cfg_we) begin
      r_cfg_read <= w_rd_data;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = 16'h0000;
    bus.mem_write = 32'h0;
    case (r_state)
      S_FILL: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 4'hF;
        bus.mem_addr  = 16'(r_dst_ptr);
        bus.mem_write = r_fill;
      end
      S_COPY_RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = 16'(r_src_ptr);
      end
      S_COPY_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 4'hF;
        bus.mem_addr  = 16'(r_dst_ptr);
        bus.mem_write = bus.mem_read;
      end
      default: ;
    endcase
  end

  assign bus.cfg_read = r_cfg_read;
  assign bus.irq      = r_done & r_irq_en;

endmodule

// File: doc/video_blitter.md
Name: video_blitter

Overview:
- Rectangle fill/copy engine that sits directly upstream of video_unit and drives its video-memory port (mem_en/mem_we/mem_addr/mem_write/mem_read) as a bus master.
- Software programs geometry through a small register port, then writes start. The block streams word writes, or read-then-write pairs, into the frame buffer.
- Runs on video_unit's mem_clk. Only ever targets the memory half of video_unit's address space: mem_addr[15]=0 always.

Parameters:
- ADDR_WIDTH, 15, word-address width of video memory. Pointers and strides wrap modulo 2**ADDR_WIDTH.
- DIM_WIDTH, 16, width of the WIDTH/HEIGHT registers and of the column/row counters.

Ports:
- clk  in  1  block clock; connects to video_unit mem_clk.
- rst  in  1  reset. Asynchronous, active-high.
- cfg_en  in  1  register access strobe.
- cfg_we  in  1  register write when cfg_en=1.
- cfg_addr  in  4  register index.
- cfg_write  in  32  register write data.
- cfg_read  out  32  register read data, registered, valid the cycle after cfg_en.
- mem_en  out  1  memory access strobe to video_unit.
- mem_we  out  4  byte write enables. 4'hF on writes, 0 on reads.
- mem_addr  out  16  {1'b0, word pointer}.
- mem_write  out  32  write data.
- mem_read  in  32  read data, valid the cycle after a read access.
- irq  out  1  level interrupt, = done & irq_en.

Behaviour:
- Registers (index: field):
  - 0 DST[14:0]
  - 1 SRC[14:0]
  - 2 WIDTH[15:0], in words
  - 3 HEIGHT[15:0], in rows
  - 4 DST_STRIDE[14:0]
  - 5 SRC_STRIDE[14:0]
  - 6 FILL[31:0]
  - 7 CTRL: bit0 start (write-1, self-clearing, reads 0); bit1 mode (0 fill, 1 copy); bit2 irq_en; bit3 abort (write-1)
  - 8 STATUS: bit0 busy; bit1 done (sticky, W1C); bit2 aborted (sticky, W1C)
  - Other indices read 0; writes to them are ignored.
- Writes to registers 0-6 and to CTRL mode/irq_en while busy=1 are ignored. STATUS W1C is always honoured.
- Reset: state IDLE; all registers 0; mem_en=0, mem_we=0, mem_addr=0, mem_write=0, cfg_read=0, irq=0.
- FSM states: IDLE, FILL, COPY_RD, COPY_WR.
- IDLE:
  - Start written at edge k with WIDTH=0 or HEIGHT=0: done=1 after edge k; no memory access; stay IDLE.
  - Otherwise, at edge k: latch dst_row=dst_ptr=DST, src_row=src_ptr=SRC, col=0, row=0, busy=1; go to FILL (mode 0) or COPY_RD (mode 1).
- Memory outputs are a combinational decode of state and pointer registers:
  - FILL: mem_en=1, mem_we=F, mem_addr=dst_ptr, mem_write=FILL.
  - COPY_RD: mem_en=1, mem_we=0, mem_addr=src_ptr.
  - COPY_WR: mem_en=1, mem_we=F, mem_addr=dst_ptr, mem_write=mem_read.
  - IDLE: all memory outputs 0.
- The first access therefore occurs in the cycle immediately after edge k.
- FILL issues one word per cycle; total W*H cycles.
- Copy issues COPY_RD then COPY_WR per word; total 2*W*H cycles.
- Pointer advance (after each FILL or COPY_WR cycle):
  - col≠W-1: col+1; dst_ptr+1; src_ptr+1.
  - col=W-1 and row≠H-1: col=0; row+1; dst_row+=DST_STRIDE; src_row+=SRC_STRIDE; pointers reload from the new row starts.
  - col=W-1 and row=H-1: go IDLE; busy=0; done=1.
- All pointer and stride arithmetic is ADDR_WIDTH bits and wraps; 0x7FFF+1=0x0000.
- Rows may overlap. Copy is strictly forward (row-major ascending). Overlap results are defined by that order.
- Abort written while busy, at edge j: state IDLE after edge j, busy=0, aborted=1, done unchanged. No access occurs in the cycle after edge j. An abort written while idle is ignored.
- Start written while busy is ignored.
- Simultaneous W1C of done in the same edge that completion sets done: set wins.
- Asynchronous reset mid-operation forces all outputs to 0 immediately. A partially written rectangle is not resumed.

Test Plan:
- Fill: DST=0x100, W=3, H=2, DST_STRIDE=0x40, FILL=0xDEADBEEF, start -> writes at 0x100,0x101,0x102,0x140,0x141,0x142 on 6 consecutive cycles, mem_we=F; busy=0 and done=1 after the 6th; irq=1 when irq_en=1.
- Copy: SRC=0x10, DST=0x200, W=2, H=2, strides 0x20; memory preloaded with 0x10→A, 0x11→B, 0x30→C, 0x31→D -> alternating read/write over 8 cycles; 0x200=A, 0x201=B, 0x220=C, 0x221=D.
- Wrap-around: DST=0x7FFE, W=3, H=1 fill -> addresses 0x7FFE, 0x7FFF, 0x0000; mem_addr[15]=0 throughout.
- Degenerate: W=0, H=5, start -> no mem_en pulse; done=1 the cycle after the start write.
- Abort and busy lockout: during a W=100 fill, write DST=0x555, then abort at word 10 -> DST reads back its old value; exactly 10 writes issued; aborted=1, done=0, busy=0.
- Reset mid-copy: assert rst between COPY_RD and COPY_WR -> mem_en, mem_we and irq drop to 0 asynchronously; after release STATUS=0 and all registers are 0.
